modulation_sampler: RTL and testbench
=====================================

Name: modulation_sampler

Overview:
- Upstream neighbour of the modulation multiplier.
- On every carrier-period strobe it fetches the current 8-bit modulation sample from modulation BRAM and presents it on M. It then pulses START to launch one multiplier pass.
- Sample index advances once every FREQ_DIV strobes and wraps at CYCLE.
- Tracks multiplier busy/done so START never arrives while a pass is in flight.

Parameters:
- ADDR_WIDTH, 15, modulation BRAM address width (buffer up to 32768 samples).
- DIV_WIDTH, 32, width of the frequency-division count.
- READ_LATENCY, 2, BRAM read latency in cycles (ADDR registered to DATA valid).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- UPDATE  in  1  one-cycle strobe at each carrier-period start.
- CYCLE  in  ADDR_WIDTH  last valid sample index (buffer size minus 1).
- FREQ_DIV  in  DIV_WIDTH  strobes per sample; 0 is treated as 1.
- ADDR  out  ADDR_WIDTH  BRAM read address.
- DATA  in  8  BRAM read data.
- M  out  8  modulation sample for the multiplier.
- START  out  1  one-cycle launch pulse to the multiplier.
- MULT_DONE  in  1  multiplier completion pulse.
- IDX  out  ADDR_WIDTH  current sample index.
- OVERRUN  out  1  sticky: a strobe was merged because a pass was still pending.

Behaviour:
- Reset values: M=0, START=0, ADDR=0, IDX=0, OVERRUN=0. Also div_cnt=0, mult_busy=0, pending=0, state=IDLE.
- Index counter, updated on every UPDATE regardless of state:
  - div_cnt <= (div_cnt >= max(FREQ_DIV,1)-1) ? 0 : div_cnt+1.
  - On that wrap, IDX <= (IDX >= CYCLE) ? 0 : IDX+1.
  - Reducing CYCLE below IDX therefore wraps to 0 on the next advance.
- Fetch address is IDX as sampled in the UPDATE cycle, before the advance.
  - FREQ_DIV=2 fetches indices 0,0,1,1,2,...
- States: IDLE, FETCH, WAIT, ISSUE.
  - IDLE: on UPDATE or pending, ADDR <= IDX, clear pending, go to FETCH.
  - FETCH / WAIT: count READ_LATENCY cycles from the ADDR update, then M <= DATA and go to ISSUE.
  - ISSUE: if !mult_busy or MULT_DONE, START <= 1, mult_busy <= 1, return to IDLE. Otherwise hold, with M stable.
- Latency: UPDATE high in cycle 0 with the multiplier idle gives START high in cycle READ_LATENCY+2 (cycle 4 by default).
- START is exactly one cycle wide. M is stable from the START cycle until the next fetch completes.
- mult_busy is cleared by MULT_DONE.
  - MULT_DONE in the same cycle as ISSUE is evaluated is treated as idle.
  - MULT_DONE while not busy is ignored.
- UPDATE while not in IDLE, or while pending:
  - sets pending;
  - if pending was already set, OVERRUN <= 1 (sticky);
  - the counters still advance.
  - Multiple strobes merge into one pass, which fetches the IDX current at the moment IDLE consumes pending.
- UPDATE in IDLE with pending set: a single fetch is issued and pending is cleared.
- Reset mid-operation returns everything to reset values immediately. No START is emitted after reset until a new UPDATE.

Decomposition:
- Package modulation_pkg holds:
  - state enum (IDLE, FETCH, WAIT, ISSUE);
  - localparams ADDR_WIDTH, DIV_WIDTH, READ_LATENCY;
  - sample type as an 8-bit logic typedef.
- One sub-module: modulation_index_counter (div_cnt/IDX with FREQ_DIV/CYCLE wrap). It is verified standalone.

Test Plan:
- BRAM model, DATA[i]=i+10, CYCLE=3, FREQ_DIV=1, UPDATE every 400 cycles, MULT_DONE 300 cycles after START -> START 4 cycles after each UPDATE; M sequence 10,11,12,13,10; OVERRUN=0.
- FREQ_DIV=3, CYCLE=1 -> M sequence 10,10,10,11,11,11,10; FREQ_DIV=0 behaves as FREQ_DIV=1.
- MULT_DONE withheld 50 cycles past the next UPDATE -> START delayed to the cycle after MULT_DONE, one pulse only; M held constant while waiting.
- Three UPDATEs while busy -> exactly one extra START; OVERRUN=1; IDX advanced by 3.
- IDX=5, then CYCLE changed to 2 -> next advance gives IDX=0.
- RST_N low during WAIT -> M=0, START=0, IDX=0 asynchronously; no START until the next UPDATE after release.

Source files
------------

// File: rtl/modulation_sampler_pkg.sv
// Shared types and constants for the modulation sampler and its index counter.
package modulation_pkg;

    localparam int ADDR_WIDTH   = 15;
    localparam int DIV_WIDTH    = 32;
    localparam int READ_LATENCY = 2;

    typedef logic [7:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE
    } state_t;

endpackage

// File: rtl/modulation_sampler_if.sv
// Sampler-side bus: modulation BRAM read port plus the multiplier launch handshake.
interface modulation_sampler_if;

    logic [modulation_pkg::ADDR_WIDTH-1:0] ADDR;
    modulation_pkg::sample_t               DATA;
    modulation_pkg::sample_t               M;
    logic                                  START;
    logic                                  MULT_DONE;

    modport master (
        output ADDR,
        output M,
        output START,
        input  DATA,
        input  MULT_DONE
    );

    modport slave (
        input  ADDR,
        input  M,
        input  START,
        output DATA,
        output MULT_DONE
    );

endinterface

// File: rtl/modulation_sampler_index_counter.sv
// Sample index: advances once every max(freq_div,1) strobes and wraps after cycle.
module modulation_index_counter
    import modulation_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] cycle,
    input  logic [DIV_WIDTH-1:0]  freq_div,
    output logic [ADDR_WIDTH-1:0] idx
);

    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_last;

    // A division of zero is treated as one, so the last count is also zero.
    assign div_last = (freq_div == '0) ? '0 : freq_div - DIV_WIDTH'(1);

    // Divider and index update; >= compares let a shrunken cycle wrap cleanly.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (advance) begin
            if (div_cnt >= div_last) begin
                div_cnt <= '0;
                idx     <= (idx >= cycle) ? '0 : idx + ADDR_WIDTH'(1);
            end else begin
                div_cnt <= div_cnt + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/modulation_sampler.sv
// Fetches one modulation sample per carrier strobe and launches a multiplier pass.
//
// state | meaning
// IDLE  | waiting for a strobe or a merged (pending) strobe
// FETCH | first cycle after ADDR was registered
// WAIT  | remaining BRAM read latency
// ISSUE | sample captured in M; waiting for the multiplier to be free
module modulation_sampler
    import modulation_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  UPDATE,
    input  logic [ADDR_WIDTH-1:0] CYCLE,
    input  logic [DIV_WIDTH-1:0]  FREQ_DIV,
    modulation_sampler_if.master  mod_bus,
    output logic [ADDR_WIDTH-1:0] IDX,
    output logic                  OVERRUN
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1);

    state_t            state;
    state_t            state_next;
    logic [LAT_W-1:0]  lat_cnt;
    logic              lat_done;
    logic              mult_busy;
    logic              pending;
    logic              fire;
    logic              load_addr;
    logic              load_m;
    logic              issue;

    modulation_index_counter u_index (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .advance  (UPDATE),
        .cycle    (CYCLE),
        .freq_div (FREQ_DIV),
        .idx      (IDX)
    );

    assign lat_done = (lat_cnt == LAT_W'(READ_LATENCY - 1));
    // A completion arriving in the issue cycle frees the multiplier for this pass.
    assign fire     = !mult_busy || mod_bus.MULT_DONE;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (UPDATE || pending) state_next = FETCH;
            FETCH, WAIT: state_next = lat_done ? ISSUE : WAIT;
            ISSUE:       if (fire) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        load_addr = 1'b0;
        load_m    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE:        load_addr = UPDATE || pending;
            FETCH, WAIT: load_m    = lat_done;
            ISSUE:       issue     = fire;
            default:     ;
        endcase
    end

    // Read address, captured sample and the one-cycle launch pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mod_bus.ADDR  <= '0;
            mod_bus.M     <= '0;
            mod_bus.START <= 1'b0;
        end else begin
            mod_bus.START <= issue;
            if (load_addr) mod_bus.ADDR <= IDX;
            if (load_m)    mod_bus.M    <= mod_bus.DATA;
        end
    end

    // Read-latency counter, restarted whenever a new address is registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                             lat_cnt <= '0;
        else if (load_addr)                     lat_cnt <= '0;
        else if (state == FETCH || state == WAIT) lat_cnt <= lat_cnt + LAT_W'(1);
    end

    // Multiplier occupancy, strobe merging and the sticky overrun flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mult_busy <= 1'b0;
            pending   <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            if (issue)                  mult_busy <= 1'b1;
            else if (mod_bus.MULT_DONE) mult_busy <= 1'b0;
            if (load_addr)   pending <= 1'b0;
            else if (UPDATE) pending <= 1'b1;
            if (UPDATE && pending) OVERRUN <= 1'b1;
        end
    end

endmodule

// File: tb/tb_modulation_sampler.sv
// Directed bench: table of strobe sequences plus hand-written busy/overrun/reset cases.
module tb_modulation_sampler;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        UPDATE = 1'b0;
    logic [14:0] CYCLE = '0;
    logic [31:0] FREQ_DIV = '0;
    logic [14:0] IDX;
    logic        OVERRUN;
    logic [7:0]  bram_q = '0;

    int n_checks = 0;
    int n_errors = 0;
    int start_count = 0;

    modulation_sampler_if mod_bus ();

    modulation_sampler dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .UPDATE   (UPDATE),
        .CYCLE    (CYCLE),
        .FREQ_DIV (FREQ_DIV),
        .mod_bus  (mod_bus),
        .IDX      (IDX),
        .OVERRUN  (OVERRUN)
    );

    always #5 CLK = ~CLK;

    // BRAM model: mem[i] = i + 10, data valid two edges after ADDR is registered.
    always @(posedge CLK) bram_q <= 8'(mod_bus.ADDR + 15'd10);
    assign mod_bus.DATA = bram_q;

    // Count launch pulses, sampled mid-cycle.
    always @(negedge CLK) if (RST_N && mod_bus.START) start_count++;

    typedef struct {
        logic [31:0]      freq_div;
        logic [14:0]      cycle;
        int               n;
        logic [0:7][7:0]  exp_m;
        logic [14:0]      exp_idx;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        UPDATE = 1'b0;
        mod_bus.MULT_DONE = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    // Optionally strobe UPDATE / MULT_DONE for one cycle, then wait (bounded) for START.
    task automatic await_start(input bit upd, input bit done, output int lat);
        lat = 0;
        UPDATE = upd;
        mod_bus.MULT_DONE = done;
        do begin
            @(negedge CLK);
            UPDATE = 1'b0;
            mod_bus.MULT_DONE = 1'b0;
            lat++;
        end while (!mod_bus.START && lat < 200);
    endtask

    task automatic pulse_update();
        UPDATE = 1'b1;
        @(negedge CLK);
        UPDATE = 1'b0;
    endtask

    task automatic pulse_done();
        mod_bus.MULT_DONE = 1'b1;
        @(negedge CLK);
        mod_bus.MULT_DONE = 1'b0;
    endtask

    initial begin
        int lat;
        int base;

        vecs[0] = '{32'd1, 15'd3, 5, {8'd10, 8'd11, 8'd12, 8'd13, 8'd10, 24'd0}, 15'd1};
        vecs[1] = '{32'd3, 15'd1, 7, {8'd10, 8'd10, 8'd10, 8'd11, 8'd11, 8'd11, 8'd10, 8'd0}, 15'd0};
        vecs[2] = '{32'd0, 15'd3, 5, {8'd10, 8'd11, 8'd12, 8'd13, 8'd10, 24'd0}, 15'd1};
        vecs[3] = '{32'd2, 15'd2, 6, {8'd10, 8'd10, 8'd11, 8'd11, 8'd12, 8'd12, 16'd0}, 15'd0};

        // Reset values while reset is held.
        mod_bus.MULT_DONE = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_m", 32'(mod_bus.M), 32'd0);
        check("rst_start", 32'(mod_bus.START), 32'd0);
        check("rst_addr", 32'(mod_bus.ADDR), 32'd0);
        check("rst_idx", 32'(IDX), 32'd0);
        check("rst_overrun", 32'(OVERRUN), 32'd0);

        // Table: one pass per strobe, multiplier always finished before the next strobe.
        for (int v = 0; v < 4; v++) begin
            apply_reset();
            FREQ_DIV = vecs[v].freq_div;
            CYCLE = vecs[v].cycle;
            base = start_count;
            for (int i = 0; i < vecs[v].n; i++) begin
                await_start(1'b1, 1'b0, lat);
                check("tbl_latency", 32'(lat), 32'd4);
                check("tbl_m", 32'(mod_bus.M), 32'(vecs[v].exp_m[i]));
                @(negedge CLK);
                check("tbl_start_width", 32'(mod_bus.START), 32'd0);
                repeat (25) @(negedge CLK);
                pulse_done();
                repeat (10) @(negedge CLK);
            end
            check("tbl_start_count", 32'(start_count - base), 32'(vecs[v].n));
            check("tbl_overrun", 32'(OVERRUN), 32'd0);
            check("tbl_idx", 32'(IDX), 32'(vecs[v].exp_idx));
        end

        // Multiplier still busy at the next strobe: START waits for MULT_DONE, M held.
        apply_reset();
        FREQ_DIV = 32'd1;
        CYCLE = 15'd3;
        await_start(1'b1, 1'b0, lat);
        check("busy_first_m", 32'(mod_bus.M), 32'd10);
        repeat (10) @(negedge CLK);
        base = start_count;
        pulse_update();
        repeat (10) @(negedge CLK);
        check("busy_hold_m_early", 32'(mod_bus.M), 32'd11);
        repeat (40) @(negedge CLK);
        check("busy_hold_m_late", 32'(mod_bus.M), 32'd11);
        check("busy_no_start", 32'(start_count - base), 32'd0);
        await_start(1'b0, 1'b1, lat);
        check("busy_start_after_done", 32'(lat), 32'd1);
        check("busy_m", 32'(mod_bus.M), 32'd11);
        @(negedge CLK);
        check("busy_start_width", 32'(mod_bus.START), 32'd0);
        repeat (20) @(negedge CLK);
        check("busy_one_start", 32'(start_count - base), 32'd1);

        // Three strobes while busy: one pass in flight, the rest merge; OVERRUN sticks.
        apply_reset();
        FREQ_DIV = 32'd1;
        CYCLE = 15'd7;
        await_start(1'b1, 1'b0, lat);
        check("ovr_first_m", 32'(mod_bus.M), 32'd10);
        repeat (5) @(negedge CLK);
        base = start_count;
        for (int k = 0; k < 3; k++) begin
            pulse_update();
            repeat (4) @(negedge CLK);
        end
        repeat (10) @(negedge CLK);
        check("ovr_no_start", 32'(start_count - base), 32'd0);
        check("ovr_flag", 32'(OVERRUN), 32'd1);
        check("ovr_idx", 32'(IDX), 32'd4);
        await_start(1'b0, 1'b1, lat);
        check("ovr_start1_lat", 32'(lat), 32'd1);
        check("ovr_start1_m", 32'(mod_bus.M), 32'd11);
        repeat (10) @(negedge CLK);
        check("ovr_one_extra", 32'(start_count - base), 32'd1);
        await_start(1'b0, 1'b1, lat);
        check("ovr_start2_lat", 32'(lat), 32'd1);
        check("ovr_start2_m", 32'(mod_bus.M), 32'd14);
        repeat (20) @(negedge CLK);
        check("ovr_total", 32'(start_count - base), 32'd2);

        // Shrinking CYCLE below IDX wraps to 0 on the next advance.
        apply_reset();
        FREQ_DIV = 32'd1;
        CYCLE = 15'd7;
        for (int k = 0; k < 5; k++) begin
            pulse_update();
            repeat (2) @(negedge CLK);
        end
        check("cyc_idx5", 32'(IDX), 32'd5);
        CYCLE = 15'd2;
        pulse_update();
        check("cyc_wrap", 32'(IDX), 32'd0);
        pulse_update();
        check("cyc_after_wrap", 32'(IDX), 32'd1);

        // Reset asserted while waiting on the BRAM.
        apply_reset();
        FREQ_DIV = 32'd1;
        CYCLE = 15'd3;
        for (int k = 0; k < 2; k++) begin
            await_start(1'b1, 1'b0, lat);
            repeat (5) @(negedge CLK);
            pulse_done();
            repeat (5) @(negedge CLK);
        end
        check("rstw_m_before", 32'(mod_bus.M), 32'd11);
        pulse_update();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("rstw_m", 32'(mod_bus.M), 32'd0);
        check("rstw_start", 32'(mod_bus.START), 32'd0);
        check("rstw_idx", 32'(IDX), 32'd0);
        check("rstw_addr", 32'(mod_bus.ADDR), 32'd0);
        base = start_count;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (30) @(negedge CLK);
        check("rstw_no_start", 32'(start_count - base), 32'd0);
        await_start(1'b1, 1'b0, lat);
        check("rstw_restart_lat", 32'(lat), 32'd4);
        check("rstw_restart_m", 32'(mod_bus.M), 32'd10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
